load_unit: RTL

Sequential load path of the memory stage: the read-side counterpart of the store decode/alignment logic. It accepts one load request at a time and decodes funct3, or forces LW for AMO/LR. It traps misaligned accesses without issuing a bus cycle, runs a word-aligned valid/ready read on the data bus, and returns the selected byte, half or word, sign- or zero-extended, with a one-cycle completion pulse.

---
 rtl/load_unit_pkg.sv | 22 ++
 rtl/load_unit_if.sv | 22 ++
 rtl/load_decoder.sv | 33 +++
 rtl/load_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared types for the load path: load operation codes and the sequencer states.
package load_unit_pkg;

    localparam int XLEN          = 32;
    localparam int LOAD_OP_WIDTH = 3;

    // Codes follow funct3 so the LOADop doubles as a readable debug value.
    typedef enum logic [LOAD_OP_WIDTH-1:0] {
        LOAD_OP_LB  = 3'd0,
        LOAD_OP_LH  = 3'd1,
        LOAD_OP_LW  = 3'd2,
        LOAD_OP_LBU = 3'd4,
        LOAD_OP_LHU = 3'd5
    } load_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/load_unit_if.sv
// Data-bus read port. Handshake: a beat completes on a clock edge where
// mem_valid and mem_ready are both 1; mem_valid and mem_addr hold until then,
// and mem_rdata/mem_error are only meaningful in that same cycle.
interface load_unit_if
    import load_unit_pkg::*;
();
    logic            mem_valid;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_error;

    modport master (
        output mem_valid, mem_addr,
        input  mem_ready, mem_rdata, mem_error
    );

    modport slave (
        input  mem_valid, mem_addr,
        output mem_ready, mem_rdata, mem_error
    );
endinterface

// File: rtl/load_decoder.sv
// Combinational load decode: funct3 (or forced LW for AMO/LR) to LOADop,
// plus the misalignment check against the low address bits.
module load_decoder
    import load_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       amo_operation_load,
    input  logic [1:0] addr_lo,
    output load_op_t   load_op,
    output logic       is_load_unaligned
);

    always_comb begin
        load_op = LOAD_OP_LW;
        if (!amo_operation_load) begin
            case (funct3[1:0])
                2'b00:   load_op = funct3[2] ? LOAD_OP_LBU : LOAD_OP_LB;
                2'b01:   load_op = funct3[2] ? LOAD_OP_LHU : LOAD_OP_LH;
                default: load_op = LOAD_OP_LW;
            endcase
        end
    end

    always_comb begin
        is_load_unaligned = 1'b0;
        case (load_op)
            LOAD_OP_LH, LOAD_OP_LHU: is_load_unaligned = addr_lo[0];
            LOAD_OP_LW:              is_load_unaligned = (addr_lo != 2'b00);
            default:                 is_load_unaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Sequential load unit: one request at a time, word-aligned bus read,
// byte/half/word extraction with sign/zero extension and trap reporting.
module load_unit
    import load_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic             amo_operation_load,
    input  logic [XLEN-1:0]  addr,
    output logic             busy,
    output logic [XLEN-1:0]  result,
    output logic             done,
    output logic             load_misaligned,
    output logic             load_access_fault,
    output state_t           dbg_state,
    load_unit_if.master      mem
);

    state_t          r_state;
    state_t          w_state_nxt;
    load_op_t        r_op;
    load_op_t        w_op;
    logic            w_unaligned;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_result;
    logic            r_misaligned;
    logic            r_fault;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_data;

    load_decoder u_decoder (
        .funct3             (funct3),
        .amo_operation_load (amo_operation_load),
        .addr_lo            (addr[1:0]),
        .load_op            (w_op),
        .is_load_unaligned  (w_unaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_unaligned ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem.mem_ready) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Halves are only reached when addr[0]=0, so shifting by 8*offset also
    // yields the 16*addr[1] half select.
    assign w_shifted = mem.mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_op)
            LOAD_OP_LB:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LOAD_OP_LBU: w_load_data = {24'd0, w_shifted[7:0]};
            LOAD_OP_LH:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LOAD_OP_LHU: w_load_data = {16'd0, w_shifted[15:0]};
            default:     w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_op         <= LOAD_OP_LW;
            r_result     <= '0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr       <= addr;
                        r_op         <= w_op;
                        r_result     <= '0;
                        r_misaligned <= w_unaligned;
                        r_fault      <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ready) begin
                        r_fault  <= mem.mem_error;
                        r_result <= mem.mem_error ? '0 : w_load_data;
                    end
                end
                ST_DONE: begin
                    // Trap flags only qualify the done cycle.
                    r_misaligned <= 1'b0;
                    r_fault      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy              = (r_state != ST_IDLE);
    assign done              = (r_state == ST_DONE);
    assign result            = r_result;
    assign load_misaligned   = r_misaligned;
    assign load_access_fault = r_fault;
    assign dbg_state         = r_state;
    assign mem.mem_valid     = (r_state == ST_REQ);
    assign mem.mem_addr      = {r_addr[XLEN-1:2], 2'b00};

endmodule
